// File: rtl/fetch_issue_if.sv
// Bundle between the fetch unit, instruction memory and the IF/ID register.
// master = fetch_issue side, slave = memory / pipeline side.
interface fetch_issue_if;
    logic        STALL;
    logic        FLUSH;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    // Req/Gnt: a request transfers on any cycle where Mem_Req and Mem_Gnt are both high; until then
    // Mem_Req and Mem_Addr hold steady unless a squash withdraws them. Mem_Rvalid has no back-pressure
    // and returns words strictly in request order.
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Gnt;
    logic        Mem_Rvalid;
    logic [31:0] Mem_Rdata;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;

    modport master (
        input  STALL, FLUSH, Redirect_Valid, Redirect_PC, Mem_Gnt, Mem_Rvalid, Mem_Rdata,
        output Mem_Req, Mem_Addr, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Instr_Valid_IF
    );

    modport slave (
        output STALL, FLUSH, Redirect_Valid, Redirect_PC, Mem_Gnt, Mem_Rvalid, Mem_Rdata,
        input  Mem_Req, Mem_Addr, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Instr_Valid_IF
    );
endinterface

// File: rtl/fetch_issue.sv
// In-order instruction fetch: issues pipelined memory reads, tags them with their PC and buffers
// returned words in a small FIFO feeding the IF/ID register. Redirects discard stale words.
module fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4
) (
    input logic         CLK,
    input logic         RESET,
    fetch_issue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int OW = 4;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [31:0]   fetch_pc;
    logic [OW-1:0] live_cnt;
    logic [OW-1:0] disc_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] fifo_rd, fifo_wr, tag_rd, tag_wr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   tag_q     [DEPTH];

    logic          squash, head_valid, mem_req, issue, drop, accept, push_en, pop, resp;
    logic [SW-1:0] live_fifo, inflight;

    always_comb begin
        squash     = bus.FLUSH || bus.Redirect_Valid;
        head_valid = (fifo_cnt != '0);
        live_fifo  = SW'(live_cnt) + SW'(fifo_cnt);
        inflight   = SW'(live_cnt) + SW'(disc_cnt);
        // Words still owed to live requests count against FIFO space, so a grant always has a slot.
        mem_req    = RESET && !squash && (live_fifo < SW'(DEPTH)) && (inflight < SW'(MAX_OUT));
        issue      = mem_req && bus.Mem_Gnt;
        drop       = bus.Mem_Rvalid && (disc_cnt != '0);
        accept     = bus.Mem_Rvalid && (disc_cnt == '0) && (live_cnt != '0);
        resp       = drop || accept;
        push_en    = accept && !squash;
        pop        = !bus.STALL && !squash && head_valid;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc <= RESET_PC;
            live_cnt <= '0;
            disc_cnt <= '0;
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else if (squash) begin
            // Everything still in flight becomes a discard; a response arriving now is already gone.
            fetch_pc <= bus.Redirect_Valid ? bus.Redirect_PC : fetch_pc;
            disc_cnt <= disc_cnt + live_cnt - OW'(resp);
            live_cnt <= '0;
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_wr   <= tag_wr + AW'(1);
            end
            if (accept) begin
                tag_rd  <= tag_rd + AW'(1);
                fifo_wr <= fifo_wr + AW'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + AW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(accept) - CW'(pop);
            live_cnt <= live_cnt + OW'(issue) - OW'(accept);
            disc_cnt <= disc_cnt - OW'(drop);
        end
    end

    always_ff @(posedge CLK) begin
        if (issue) begin
            tag_q[tag_wr] <= fetch_pc;
        end
        if (push_en) begin
            fifo_data[fifo_wr] <= bus.Mem_Rdata;
            fifo_pc[fifo_wr]   <= tag_q[tag_rd];
        end
    end

    always_comb begin
        bus.Mem_Req           = mem_req;
        bus.Mem_Addr          = fetch_pc;
        bus.Instr_Valid_IF    = head_valid;
        bus.Instr1_IF         = head_valid ? fifo_data[fifo_rd] : 32'h0;
        bus.Instr_PC_IF       = head_valid ? fifo_pc[fifo_rd] : 32'h0;
        bus.Instr_PC_Plus4_IF = head_valid ? fifo_pc[fifo_rd] + 32'd4 : 32'h0;
    end

    a_space: assert property (@(posedge CLK) disable iff (!RESET) live_fifo <= SW'(DEPTH));
    a_outstanding: assert property (@(posedge CLK) disable iff (!RESET) inflight <= SW'(MAX_OUT));
    a_overflow: assert property (@(posedge CLK) disable iff (!RESET)
        !(push_en && !pop && (fifo_cnt == CW'(DEPTH))));
    a_underflow: assert property (@(posedge CLK) disable iff (!RESET) !(pop && !head_valid));
endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: directed vector table, hand-built redirect/flush/wrap sequences and
// random traffic checked against a queue-based model of the fetch stream.
module tb_fetch_issue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;
    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    fetch_issue_if bus ();

    fetch_issue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    req_t        pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RST_PC;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          spur_en = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_p4, s_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: memory drives its response, outputs are compared against the model, model advances.
    task automatic step();
        logic        sq, er, push;
        logic [31:0] hp, epc;
        int          live;
        req_t        h;
        push = 1'b0;
        hp   = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.Mem_Rvalid = 1'b1;
            bus.Mem_Rdata  = word_of(pend_q[0].addr);
        end else if (pend_q.size() == 0 && spur_en && $urandom_range(0, 9) == 0) begin
            bus.Mem_Rvalid = 1'b1;
            bus.Mem_Rdata  = $urandom;
        end else begin
            bus.Mem_Rvalid = 1'b0;
            bus.Mem_Rdata  = $urandom;
        end
        #1;
        s_req   = bus.Mem_Req;
        s_addr  = bus.Mem_Addr;
        s_valid = bus.Instr_Valid_IF;
        s_pc    = bus.Instr_PC_IF;
        s_p4    = bus.Instr_PC_Plus4_IF;
        s_instr = bus.Instr1_IF;

        sq = bus.FLUSH || bus.Redirect_Valid;
        live = 0;
        foreach (pend_q[i]) if (!pend_q[i].stale) live++;
        er  = !sq && (live + exp_q.size() < DEPTH) && (pend_q.size() < MAX_OUT);
        epc = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        check("mem_req", 32'(s_req), 32'(er));
        check("mem_addr", s_addr, model_pc);
        check("instr_valid", 32'(s_valid), 32'(exp_q.size() > 0));
        check("instr_pc", s_pc, epc);
        check("instr_plus4", s_p4, (exp_q.size() > 0) ? epc + 32'd4 : 32'h0);
        check("instr_word", s_instr, (exp_q.size() > 0) ? word_of(epc) : 32'h0);

        if (bus.Mem_Rvalid && pend_q.size() > 0) begin
            h = pend_q.pop_front();
            if (!h.stale && !sq) begin
                push = 1'b1;
                hp   = h.addr;
            end
        end
        if (!sq && !bus.STALL && exp_q.size() > 0) void'(exp_q.pop_front());
        if (push) exp_q.push_back(hp);
        if (er && bus.Mem_Gnt) begin
            pend_q.push_back('{addr: model_pc, stale: 1'b0,
                               due: cyc + int'($urandom_range(lat_min, lat_max))});
            model_pc = model_pc + 32'd4;
        end
        if (sq) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            if (bus.Redirect_Valid) model_pc = bus.Redirect_PC;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.STALL          = 1'b0;
        bus.FLUSH          = 1'b0;
        bus.Redirect_Valid = 1'b0;
        bus.Redirect_PC    = 32'h0;
        bus.Mem_Gnt        = 1'b0;
        bus.Mem_Rvalid     = 1'b0;
        bus.Mem_Rdata      = 32'h0;
    endtask

    // Asserts reset mid-cycle, checks the reset outputs, releases on a falling edge.
    task automatic do_reset();
        #2;
        RESET = 1'b0;
        idle_inputs();
        @(negedge CLK);
        #1;
        check("rst_req", 32'(bus.Mem_Req), 32'h0);
        check("rst_addr", bus.Mem_Addr, RST_PC);
        check("rst_valid", 32'(bus.Instr_Valid_IF), 32'h0);
        check("rst_pc", bus.Instr_PC_IF, 32'h0);
        check("rst_plus4", bus.Instr_PC_Plus4_IF, 32'h0);
        check("rst_word", bus.Instr1_IF, 32'h0);
        pend_q.delete();
        exp_q.delete();
        model_pc = RST_PC;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic run_until_valid(input string name, input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_valid && n < bound);
        check(name, 32'(s_valid), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[15];
        int   n;
        logic [31:0] r;
        vecs[0]  = '{1'b0, 1'b1, 32'hBFC00000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'hBFC00004, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'hBFC00008, 1'b1, 32'hBFC00000};
        vecs[3]  = '{1'b0, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00004};
        vecs[4]  = '{1'b1, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC00008};
        vecs[5]  = '{1'b1, 1'b1, 32'hBFC00014, 1'b1, 32'hBFC00008};
        vecs[6]  = '{1'b1, 1'b0, 32'hBFC00018, 1'b1, 32'hBFC00008};
        vecs[7]  = '{1'b1, 1'b0, 32'hBFC00018, 1'b1, 32'hBFC00008};
        vecs[8]  = '{1'b1, 1'b0, 32'hBFC00018, 1'b1, 32'hBFC00008};
        vecs[9]  = '{1'b0, 1'b0, 32'hBFC00018, 1'b1, 32'hBFC00008};
        vecs[10] = '{1'b0, 1'b1, 32'hBFC00018, 1'b1, 32'hBFC0000C};
        vecs[11] = '{1'b0, 1'b1, 32'hBFC0001C, 1'b1, 32'hBFC00010};
        vecs[12] = '{1'b0, 1'b1, 32'hBFC00020, 1'b1, 32'hBFC00014};
        vecs[13] = '{1'b0, 1'b1, 32'hBFC00024, 1'b1, 32'hBFC00018};
        vecs[14] = '{1'b0, 1'b1, 32'hBFC00028, 1'b1, 32'hBFC0001C};

        idle_inputs();
        do_reset();

        // Straight-line stream and a five-cycle stall, one-cycle memory.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 15; i++) begin
            bus.STALL   = vecs[i].stall;
            bus.Mem_Gnt = 1'b1;
            step();
            check("vec_req", 32'(s_req), 32'(vecs[i].exp_req));
            check("vec_addr", s_addr, vecs[i].exp_addr);
            check("vec_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
            check("vec_pc", s_pc, vecs[i].exp_pc);
            check("vec_plus4", s_p4, vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0);
        end

        // Redirect with three requests outstanding.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        bus.Mem_Gnt = 1'b1;
        n = 0;
        while (pend_q.size() != 3 && n < 20) begin
            step();
            n++;
        end
        check("redir_setup", 32'(pend_q.size()), 32'd3);
        bus.Redirect_Valid = 1'b1;
        bus.Redirect_PC    = 32'h00400020;
        step();
        bus.Redirect_Valid = 1'b0;
        run_until_valid("redir_wait", 30);
        check("redir_pc", s_pc, 32'h00400020);
        check("redir_plus4", s_p4, 32'h00400024);

        // FLUSH alone at BFC00010 with two outstanding.
        do_reset();
        lat_min = 2;
        lat_max = 2;
        bus.Mem_Gnt = 1'b1;
        n = 0;
        while (model_pc != 32'hBFC00010 && n < 20) begin
            step();
            n++;
        end
        check("flush_setup", 32'(pend_q.size()), 32'd2);
        bus.FLUSH = 1'b1;
        step();
        check("flush_addr", s_addr, 32'hBFC00010);
        bus.FLUSH = 1'b0;
        step();
        check("flush_valid", 32'(s_valid), 32'h0);
        check("flush_pc", s_pc, 32'h0);
        run_until_valid("flush_wait", 30);
        check("flush_resume", s_pc, 32'hBFC00010);

        // Redirect to the top word: Plus4 and the following fetch wrap to zero.
        lat_min = 1;
        lat_max = 1;
        bus.Redirect_Valid = 1'b1;
        bus.Redirect_PC    = 32'hFFFFFFFC;
        step();
        bus.Redirect_Valid = 1'b0;
        run_until_valid("wrap_wait", 30);
        check("wrap_pc", s_pc, 32'hFFFFFFFC);
        check("wrap_plus4", s_p4, 32'h00000000);
        step();
        check("wrap_next", s_pc, 32'h00000000);

        // Random traffic with variable latency, squashes, stalls and a mid-run reset.
        spur_en = 1'b1;
        lat_min = 1;
        lat_max = 6;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            r = $urandom;
            r[1:0] = 2'b00;
            bus.STALL          = ($urandom_range(0, 99) < 30);
            bus.Mem_Gnt        = ($urandom_range(0, 99) < 60);
            bus.FLUSH          = ($urandom_range(0, 99) < 2);
            bus.Redirect_Valid = ($urandom_range(0, 99) < 3);
            bus.Redirect_PC    = r;
            step();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
